// File: rtl/rr_mux_arbiter_8.sv
// Round-robin arbiter for one shared 8:1 mux channel. It drives the mux select and a one-hot grant,
// and lets the holder keep the channel for bursts of up to MAX_BURST accepted beats.
module rr_mux_arbiter_8 #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       out_valid,
  output logic [7:0] ack,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [4:0] MAX_BURST_W = 5'(MAX_BURST);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;

  logic       req_sel;
  logic       beat;
  logic       release_grant;
  logic [4:0] burst_inc;
  logic [2:0] search_start;
  logic [2:0] winner;

  // First requester at or after p in circular order; scanning downward lets the nearest hit win.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] res;
    res = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  always_comb begin
    busy      = (state_q == GRANT);
    req_sel   = req[sel_q];
    out_valid = busy & req_sel;
    beat      = out_valid & out_ready;
    ack       = gnt_q & {8{beat}};
    sel       = sel_q;
    gnt       = gnt_q;
  end

  // A releasing holder restarts the search just past itself, so it is considered last.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    burst_cnt_d   = burst_cnt_q;
    release_grant = 1'b0;
    burst_inc     = {1'b0, burst_cnt_q} + 5'd1;
    search_start  = busy ? (sel_q + 3'd1) : ptr_q;
    winner        = pick(req, search_start);

    case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          state_d     = GRANT;
          sel_d       = winner;
          gnt_d       = 8'h01 << winner;
          burst_cnt_d = 4'd0;
        end
      end
      GRANT: begin
        if (!req_sel) begin
          release_grant = 1'b1;
        end else if (out_ready) begin
          if ((burst_inc < MAX_BURST_W) && en) begin
            burst_cnt_d = burst_inc[3:0];
          end else begin
            release_grant = 1'b1;
          end
        end

        if (release_grant) begin
          ptr_d = sel_q + 3'd1;
          if (en && (|req)) begin
            sel_d       = winner;
            gnt_d       = 8'h01 << winner;
            burst_cnt_d = 4'd0;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'h00;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 3'd0;
      ptr_q       <= 3'd0;
      gnt_q       <= 8'h00;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// Bench for rr_mux_arbiter_8: two instances (burst limit 4 and 1) share stimulus, and both are
// compared every cycle against an ownership model, plus directed literal expectations.
module tb_rr_mux_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       out_ready = 1'b0;

  logic [2:0] sel4, sel1;
  logic [7:0] gnt4, gnt1, ack4, ack1;
  logic       vld4, vld1, busy4, busy1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_8 #(.MAX_BURST(4)) dut_b4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
    .sel(sel4), .gnt(gnt4), .out_valid(vld4), .ack(ack4), .busy(busy4)
  );

  rr_mux_arbiter_8 #(.MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
    .sel(sel1), .gnt(gnt1), .out_valid(vld1), .ack(ack1), .busy(busy1)
  );

  // Model: who owns the channel (-1 = nobody), beats taken, where the next search starts.
  typedef struct packed {
    int owner;
    int ptr;
    int beats;
    int last;
  } st_t;

  st_t m4, m1;

  function automatic st_t reset_st();
    st_t s;
    s.owner = -1;
    s.ptr   = 0;
    s.beats = 0;
    s.last  = 0;
    return s;
  endfunction

  function automatic int pick(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (p + k) % 8;
      if (r[i[2:0]]) return i;
    end
    return p;
  endfunction

  function automatic st_t step(st_t s, int mb, logic en_i, logic [7:0] r, logic rdy);
    st_t n;
    bit  give_up;
    n = s;
    give_up = 1'b0;
    if (s.owner < 0) begin
      if (en_i && r != 8'h00) begin
        n.owner = pick(r, s.ptr);
        n.beats = 0;
        n.last  = n.owner;
      end
    end else begin
      if (!r[s.owner[2:0]]) give_up = 1'b1;
      else if (rdy) begin
        if (s.beats + 1 >= mb || !en_i) give_up = 1'b1;
        else n.beats = s.beats + 1;
      end
      if (give_up) begin
        n.ptr = (s.owner + 1) % 8;
        if (en_i && r != 8'h00) begin
          n.owner = pick(r, n.ptr);
          n.beats = 0;
          n.last  = n.owner;
        end else begin
          n.owner = -1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 <= reset_st();
      m1 <= reset_st();
    end else begin
      m4 <= step(m4, 4, en, req, out_ready);
      m1 <= step(m1, 1, en, req, out_ready);
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cmp_inst(string tag, st_t s, logic [2:0] a_sel, logic [7:0] a_gnt,
                          logic a_vld, logic [7:0] a_ack, logic a_busy);
    int e_sel, e_gnt, e_vld, e_ack, e_busy;
    e_busy = (s.owner >= 0) ? 1 : 0;
    e_sel  = (s.owner >= 0) ? s.owner : s.last;
    e_gnt  = (s.owner >= 0) ? (1 << s.owner) : 0;
    e_vld  = (s.owner >= 0 && req[s.owner[2:0]]) ? 1 : 0;
    e_ack  = (e_vld == 1 && out_ready) ? e_gnt : 0;
    chk({tag, ".sel"},       int'(a_sel),  e_sel);
    chk({tag, ".gnt"},       int'(a_gnt),  e_gnt);
    chk({tag, ".out_valid"}, int'(a_vld),  e_vld);
    chk({tag, ".ack"},       int'(a_ack),  e_ack);
    chk({tag, ".busy"},      int'(a_busy), e_busy);
  endtask

  always @(negedge clk) begin
    cmp_inst("model_b4", m4, sel4, gnt4, vld4, ack4, busy4);
    cmp_inst("model_b1", m1, sel1, gnt1, vld1, ack1, busy1);
  end

  // Pulse reset away from clock edges; returns just after a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    en = 1'b0;
    req = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int exp3[9];
    exp3 = '{2, 2, 2, 2, 5, 5, 5, 5, 2};

    // Reset state, then reset asserted mid-burst.
    #3;
    chk("reset.gnt", int'(gnt4), 0);
    chk("reset.sel", int'(sel4), 0);
    chk("reset.out_valid", int'(vld4), 0);
    do_reset();
    en = 1'b1; req = 8'hFF; out_ready = 1'b1;
    @(negedge clk);
    chk("t1.first_grant_sel", int'(sel4), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1.async_gnt", int'(gnt4), 0);
    chk("t1.async_sel", int'(sel4), 0);
    chk("t1.async_out_valid", int'(vld4), 0);
    chk("t1.async_ack", int'(ack4), 0);
    req = 8'h01;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t1.regrant_gnt", int'(gnt4), 8'h01);

    // Burst limit 1: full rotation without bubbles.
    do_reset();
    en = 1'b1; req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t2.sel", int'(sel1), i % 8);
      chk("t2.ack", int'(ack1), 1 << (i % 8));
    end

    // Burst limit 4 between two requesters.
    do_reset();
    en = 1'b1; req = 8'h24; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t3.sel", int'(sel4), exp3[i]);
      chk("t3.ack", int'(ack4), 1 << exp3[i]);
    end

    // Backpressure holds everything; the burst count must not advance while stalled.
    do_reset();
    en = 1'b1; req = 8'h08; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4.stall_sel", int'(sel4), 3);
      chk("t4.stall_gnt", int'(gnt4), 8'h08);
      chk("t4.stall_out_valid", int'(vld4), 1);
      chk("t4.stall_ack", int'(ack4), 0);
    end
    #2 out_ready = 1'b1; req = 8'h09;
    #1 chk("t4.first_ready_ack", int'(ack4), 8'h08);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4.burst_sel", int'(sel4), 3);
      chk("t4.burst_ack", int'(ack4), 8'h08);
    end
    @(negedge clk);
    chk("t4.rotate_sel", int'(sel4), 0);

    // Withdrawal of the granted request.
    do_reset();
    en = 1'b1; req = 8'h48; out_ready = 1'b0;
    @(negedge clk);
    chk("t5.sel", int'(sel4), 3);
    chk("t5.out_valid", int'(vld4), 1);
    #2 req = 8'h40;
    #1 chk("t5.withdraw_out_valid", int'(vld4), 0);
    @(negedge clk);
    chk("t5.next_sel", int'(sel4), 6);
    chk("t5.next_gnt", int'(gnt4), 8'h40);

    // Enable dropped mid-burst: in-flight beat completes, then idle; re-enable wraps to 0.
    do_reset();
    en = 1'b1; req = 8'h02; out_ready = 1'b0;
    @(negedge clk);
    chk("t6.sel", int'(sel4), 1);
    #2 req = 8'h03; en = 1'b0; out_ready = 1'b1;
    #1 chk("t6.inflight_ack", int'(ack4), 8'h02);
    @(negedge clk);
    chk("t6.idle_gnt", int'(gnt4), 0);
    chk("t6.idle_busy", int'(busy4), 0);
    chk("t6.idle_sel_held", int'(sel4), 1);
    #2 en = 1'b1;
    @(negedge clk);
    chk("t6.wrap_sel", int'(sel4), 0);
    chk("t6.wrap_gnt", int'(gnt4), 8'h01);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
